// File: rtl/rib_rr_arbiter.sv
// Round-robin arbiter sharing one system-bus slave port among four masters
// (JTAG debug, UART loader, core load/store, core fetch), with timeout and core hold.
module rib_rr_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          m_req_i,
  input  logic [3:0]          m_we_i,
  input  logic [4*ADDR_W-1:0] m_addr_i,
  input  logic [4*DATA_W-1:0] m_wdata_i,
  output logic [DATA_W-1:0]   m_rdata_o,
  output logic [3:0]          m_ack_o,
  output logic                m_err_o,
  output logic                s_req_o,
  output logic                s_we_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  input  logic [DATA_W-1:0]   s_rdata_i,
  input  logic                s_ack_i,
  output logic                hold_o,
  output logic [1:0]          grant_o
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_next;
  logic [1:0]        grant, last_grant;
  logic [1:0]        pick, idx;
  logic              pick_valid;
  logic [7:0]        cnt;
  logic              timeout_hit;
  logic [ADDR_W-1:0] addr_arr  [4];
  logic [DATA_W-1:0] wdata_arr [4];

  for (genvar g = 0; g < 4; g++) begin : g_unpack
    assign addr_arr[g]  = m_addr_i[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = m_wdata_i[g*DATA_W +: DATA_W];
  end

  // Search starts just after the last winner; k=4 wraps back to last_grant itself.
  always_comb begin
    pick       = last_grant;
    pick_valid = 1'b0;
    idx        = last_grant;
    for (int k = 1; k <= 4; k++) begin
      idx = last_grant + 2'(k);
      if (!pick_valid && m_req_i[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  assign timeout_hit = (cnt == 8'(TIMEOUT - 1));
  assign grant_o     = grant;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (pick_valid) state_next = BUSY;
      BUSY:    if (s_ack_i || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hold_o = 1'b0;
    if (!rst)
      hold_o = (m_req_i[2] & ~m_ack_o[2]) | (m_req_i[3] & ~m_ack_o[3]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= 2'd3;
      last_grant <= 2'd3;
      cnt        <= '0;
      s_req_o    <= 1'b0;
      s_we_o     <= 1'b0;
      s_addr_o   <= '0;
      s_wdata_o  <= '0;
      m_rdata_o  <= '0;
      m_ack_o    <= '0;
      m_err_o    <= 1'b0;
    end else begin
      m_ack_o <= '0;
      m_err_o <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (pick_valid) begin
            grant     <= pick;
            s_req_o   <= 1'b1;
            s_we_o    <= m_we_i[pick];
            s_addr_o  <= addr_arr[pick];
            s_wdata_o <= wdata_arr[pick];
          end
        end
        BUSY: begin
          // A slave ack on the last allowed cycle still completes normally.
          if (s_ack_i) begin
            s_req_o   <= 1'b0;
            m_ack_o   <= 4'b0001 << grant;
            m_rdata_o <= s_we_o ? '0 : s_rdata_i;
          end else if (timeout_hit) begin
            s_req_o   <= 1'b0;
            m_ack_o   <= 4'b0001 << grant;
            m_err_o   <= 1'b1;
            m_rdata_o <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          last_grant <= grant;
          cnt        <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rib_rr_arbiter.sv
// Self-checking bench for rib_rr_arbiter: vector table of single-master transactions,
// hand sequences for rotation and reset, and an ack scoreboard checked by a monitor.
module tb_rib_rr_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0]      m_req_i;
  logic [3:0]      m_we_i;
  logic [4*AW-1:0] m_addr_i;
  logic [4*DW-1:0] m_wdata_i;
  logic [DW-1:0]   m_rdata_o;
  logic [3:0]      m_ack_o;
  logic            m_err_o;
  logic            s_req_o;
  logic            s_we_o;
  logic [AW-1:0]   s_addr_o;
  logic [DW-1:0]   s_wdata_o;
  logic [DW-1:0]   s_rdata_i;
  logic            s_ack_i;
  logic            hold_o;
  logic [1:0]      grant_o;

  rib_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req_i(m_req_i), .m_we_i(m_we_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i), .m_rdata_o(m_rdata_o),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .s_req_o(s_req_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_rdata_i(s_rdata_i),
    .s_ack_i(s_ack_i), .hold_o(hold_o), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          master;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          master;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitSreq(output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      cycles++;
      if (s_req_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("sreq_wait_expired", 0, 1);
  endtask

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && m_ack_o != 4'b0) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_ack", 64'(m_ack_o), 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("sb_ack_vec", 64'(m_ack_o), 64'(4'b0001 << mon_e.master));
        checkOutput("sb_rdata", 64'(m_rdata_o), 64'(mon_e.rdata));
        checkOutput("sb_err", 64'(m_err_o), 64'(mon_e.err));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    bit   ok;
    int   c;
    int   n_wait;
    e.master = v.master;
    e.err    = v.exp_err;
    e.rdata  = (v.exp_err || v.we) ? 32'h0 : v.rdata;
    m_req_i               = 4'b0001 << v.master;
    m_we_i[v.master]      = v.we;
    m_addr_i[v.master*AW +: AW]  = v.addr;
    m_wdata_i[v.master*DW +: DW] = v.wdata;
    sb.push_back(e);
    waitSreq(ok, c);
    if (ok) begin
      checkOutput("sreq_latency", 64'(c), 1);
      checkOutput("s_addr", 64'(s_addr_o), 64'(v.addr));
      checkOutput("s_we", 64'(s_we_o), 64'(v.we));
      checkOutput("s_wdata", 64'(s_wdata_o), 64'(v.wdata));
      checkOutput("grant", 64'(grant_o), 64'(v.master));
      checkOutput("hold_busy", 64'(hold_o), 64'(v.master >= 2));
      n_wait = (v.delay < 0) ? TO - 1 : v.delay;
      for (int i = 0; i < n_wait; i++) begin
        m_we_i[v.master]             = ~v.we;
        m_addr_i[v.master*AW +: AW]  = $urandom;
        m_wdata_i[v.master*DW +: DW] = $urandom;
        tick();
        checkOutput("ack_early", 64'(m_ack_o), 0);
        checkOutput("s_req_held", 64'(s_req_o), 1);
        checkOutput("s_addr_held", 64'(s_addr_o), 64'(v.addr));
        checkOutput("s_wdata_held", 64'(s_wdata_o), 64'(v.wdata));
        checkOutput("s_we_held", 64'(s_we_o), 64'(v.we));
      end
      if (v.delay >= 0) begin
        s_ack_i   = 1'b1;
        s_rdata_i = v.rdata;
      end
      tick();
      s_ack_i   = 1'b0;
      s_rdata_i = $urandom;
      checkOutput("ack_vec", 64'(m_ack_o), 64'(4'b0001 << v.master));
      checkOutput("ack_err", 64'(m_err_o), 64'(v.exp_err));
      checkOutput("s_req_done", 64'(s_req_o), 0);
      checkOutput("hold_done", 64'(hold_o), 0);
      m_req_i = 4'b0;
      tick();
      checkOutput("ack_pulse_len", 64'(m_ack_o), 0);
    end
    m_req_i = 4'b0;
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ok;
    int c;
    int prev;
    vec_t v;
    exp_t e;

    vecs[0] = '{2, 1'b0, 32'h1000_0004, 32'h0,         3,  32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h0000_0020, 32'h0000_0055, 2,  32'h7777_7777, 1'b0};
    vecs[2] = '{0, 1'b0, 32'h0000_0100, 32'h0,         0,  32'h1234_5678, 1'b0};
    vecs[3] = '{3, 1'b1, 32'h8000_0000, 32'hCAFE_F00D, 1,  32'h1111_1111, 1'b0};
    vecs[4] = '{2, 1'b0, 32'h0000_0ABC, 32'h0,         -1, 32'h0,         1'b1};
    vecs[5] = '{1, 1'b0, 32'h0000_0444, 32'h0,         TO-1, 32'h5A5A_A5A5, 1'b0};
    vecs[6] = '{3, 1'b0, 32'h0000_0888, 32'h0,         0,  32'hFEED_0001, 1'b0};

    rst       = 1'b1;
    m_req_i   = 4'b0100;
    m_we_i    = 4'b0;
    m_addr_i  = '0;
    m_wdata_i = '0;
    s_ack_i   = 1'b0;
    s_rdata_i = '0;
    tick();
    tick();
    checkOutput("rst_s_req", 64'(s_req_o), 0);
    checkOutput("rst_grant", 64'(grant_o), 3);
    checkOutput("rst_ack", 64'(m_ack_o), 0);
    checkOutput("rst_err", 64'(m_err_o), 0);
    checkOutput("rst_s_we", 64'(s_we_o), 0);
    checkOutput("rst_s_addr", 64'(s_addr_o), 0);
    checkOutput("rst_s_wdata", 64'(s_wdata_o), 0);
    checkOutput("rst_rdata", 64'(m_rdata_o), 0);
    checkOutput("rst_hold", 64'(hold_o), 0);
    m_req_i = 4'b0;
    rst     = 1'b0;
    tick();

    $display("[TB] round-robin with all masters requesting");
    for (int k = 0; k < 4; k++) m_addr_i[k*AW +: AW] = 32'h100 * k;
    m_req_i = 4'hF;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      e.master = k % 4;
      e.rdata  = 32'hA000_0000 + k;
      e.err    = 1'b0;
      sb.push_back(e);
      waitSreq(ok, c);
      checkOutput("rr_grant", 64'(grant_o), 64'(k % 4));
      checkOutput("rr_addr", 64'(s_addr_o), 64'(32'h100 * (k % 4)));
      if (k > 0) checkOutput("rr_spacing", 64'(cyc - prev), 3);
      prev = cyc;
      s_ack_i   = 1'b1;
      s_rdata_i = 32'hA000_0000 + k;
      tick();
      s_ack_i = 1'b0;
      checkOutput("rr_ack", 64'(m_ack_o), 64'(4'b0001 << (k % 4)));
      if (k == 4) m_req_i = 4'b0;
      tick();
      checkOutput("rr_pulse", 64'(m_ack_o), 0);
    end

    $display("[TB] vector table");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

    $display("[TB] reset while busy");
    m_req_i = 4'b1000;
    m_addr_i[3*AW +: AW] = 32'h0000_0F00;
    waitSreq(ok, c);
    tick();
    rst     = 1'b1;
    m_req_i = 4'b0;
    tick();
    checkOutput("rstb_s_req", 64'(s_req_o), 0);
    checkOutput("rstb_grant", 64'(grant_o), 3);
    checkOutput("rstb_ack", 64'(m_ack_o), 0);
    rst       = 1'b0;
    s_ack_i   = 1'b1;
    s_rdata_i = 32'hBAD0_BAD0;
    tick();
    s_ack_i = 1'b0;
    checkOutput("stray_ack_ignored", 64'(m_ack_o), 0);
    checkOutput("stray_s_req", 64'(s_req_o), 0);
    tick();
    checkOutput("stray_ack_late", 64'(m_ack_o), 0);

    v = '{0, 1'b0, 32'h0000_0040, 32'h0, 1, 32'h0BAD_CAFE, 1'b0};
    applyStimulus(v);

    tick();
    checkOutput("sb_pending", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
